// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame constants, register map and state type for the SPI controller
package spi_pkg;

    localparam int FRAME_LEN = 16;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_controller_tick_gen.sv
// rtl/spi_controller_tick_gen.sv - loadable down-counter; expire is high on the last cycle of a loaded interval
module spi_tick_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    // Loading N makes expire fire on the N-th cycle after the load edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - mode-0 SPI initiator serialising {rw, addr, data} as a 16-bit MSB-first frame
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 5,
    parameter int CS_HOLD  = 5,
    parameter int CS_GAP   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);

    state_t                 state;
    logic [FRAME_LEN-1:0]   shreg;
    logic [3:0]             bit_cnt;
    logic                   load;
    logic [CNT_W-1:0]       load_val;
    logic                   expire;

    assign req_ready = (state == IDLE) && !rst;

    spi_tick_gen #(
        .W(CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // Every state exit reloads the timer with the length of the phase being entered.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    load     = 1'b1;
                    load_val = CNT_W'(CS_SETUP);
                end
            end
            SETUP: begin
                if (expire) begin
                    load     = 1'b1;
                    load_val = CNT_W'(CLK_DIV);
                end
            end
            SHIFT: begin
                if (expire) begin
                    load     = 1'b1;
                    load_val = (!SCLK && bit_cnt == 4'd0) ? CNT_W'(CS_HOLD) : CNT_W'(CLK_DIV);
                end
            end
            HOLD: begin
                if (expire) begin
                    load     = 1'b1;
                    load_val = CNT_W'(CS_GAP);
                end
            end
            default: begin
                load     = 1'b0;
                load_val = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            COPI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        shreg   <= {req_rw, req_addr, req_data};
                        COPI    <= req_rw;
                        nCS     <= 1'b0;
                        SCLK    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= 4'd15;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (expire) begin
                        SCLK  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (expire) begin
                        if (SCLK) begin
                            // Rotating keeps shreg[FRAME_LEN-1] holding the bit currently on COPI.
                            SCLK  <= 1'b0;
                            shreg <= {shreg[FRAME_LEN-2:0], shreg[FRAME_LEN-1]};
                            COPI  <= shreg[FRAME_LEN-2];
                        end else if (bit_cnt == 4'd0) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            SCLK    <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (expire) begin
                        nCS   <= 1'b1;
                        done  <= 1'b1;
                        COPI  <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (expire) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - randomized bench for spi_controller against a bus-level frame and register model
module tb_spi_controller;
    import spi_pkg::*;

    localparam int CLK_DIV  = 5;
    localparam int CS_SETUP = 5;
    localparam int CS_HOLD  = 5;
    localparam int CS_GAP   = 10;
    localparam int LOW_LEN  = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
    localparam int PERIOD   = 1 + LOW_LEN + CS_GAP;
    localparam int LOW_LEN3 = 1 + 32 * 3 + 1;

    typedef struct {
        logic [15:0] bits;
        int          edges;
        int          low_len;
        int          gap_before;
        logic        done_at_rise;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, busy, done, nCS, SCLK, COPI;

    logic       r3_valid = 1'b0;
    logic       r3_rw = 1'b0;
    logic [6:0] r3_addr = '0;
    logic [7:0] r3_data = '0;
    logic       r3_ready, busy3, done3, ncs3, sclk3, copi3;

    int errors = 0;
    int checks = 0;

    always #50 clk = ~clk;

    spi_controller dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .busy(busy), .done(done), .nCS(nCS), .SCLK(SCLK), .COPI(COPI)
    );

    spi_controller #(.CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut3 (
        .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
        .req_rw(r3_rw), .req_addr(r3_addr), .req_data(r3_data),
        .busy(busy3), .done(done3), .nCS(ncs3), .SCLK(sclk3), .COPI(copi3)
    );

    a_copi_stable: assert property (@(posedge clk) disable iff (rst)
        (SCLK && $past(SCLK)) |-> $stable(COPI)) else $error("FAIL copi_stable on default build");
    a_copi_stable3: assert property (@(posedge clk) disable iff (rst)
        (sclk3 && $past(sclk3)) |-> $stable(copi3)) else $error("FAIL copi_stable on CLK_DIV=3 build");

    // Bus observer acting as the peripheral: decodes frames and keeps its own register file.
    frame_t      frames[$];
    int          captures[$];
    logic [7:0]  bus_regs[128];
    logic [7:0]  ref_regs[128];
    int          cyc = 0, done_cnt = 0, viol = 0, inv_bad = 0;
    int          gap_len = 0, gap_rec = 0, low_len = 0, edges = 0;
    logic [15:0] bits = '0;
    logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (req_valid && req_ready) captures.push_back(cyc);
        if (!rst && (req_ready === busy)) inv_bad++;
        if (done === 1'b1) done_cnt++;
        if (p_sclk && SCLK && (COPI !== p_copi)) viol++;
        if (nCS === 1'b0) begin
            if (p_ncs) begin
                low_len = 0; edges = 0; bits = '0; gap_rec = gap_len;
            end
            low_len++;
            if (SCLK && !p_sclk) begin
                edges++;
                bits = {bits[14:0], COPI};
            end
        end else begin
            if (!p_ncs) begin
                frames.push_back('{bits, edges, low_len, gap_rec, done});
                if (edges == 16 && bits[15] == RW_WRITE) bus_regs[bits[14:8]] = bits[7:0];
                gap_len = 0;
            end
            gap_len++;
        end
        p_ncs = nCS; p_sclk = SCLK; p_copi = COPI;
    end

    frame_t      frames3[$];
    int          low3 = 0, edges3 = 0, hi_run3 = 0, lo_run3 = 0, viol3 = 0;
    int          hi_min3 = 1000, hi_max3 = 0, lo_min3 = 1000, lo_max3 = 0;
    logic [15:0] bits3 = '0;
    logic        p_ncs3 = 1'b1, p_sclk3 = 1'b0, p_copi3 = 1'b0;

    always @(negedge clk) begin
        #1;
        if (p_sclk3 && sclk3 && (copi3 !== p_copi3)) viol3++;
        if (sclk3 === 1'b1) hi_run3++;
        else if (p_sclk3) begin
            if (hi_run3 < hi_min3) hi_min3 = hi_run3;
            if (hi_run3 > hi_max3) hi_max3 = hi_run3;
            hi_run3 = 0;
        end
        if (ncs3 === 1'b0) begin
            if (p_ncs3) begin
                low3 = 0; edges3 = 0; bits3 = '0; lo_run3 = 0;
            end
            low3++;
            if (sclk3 && !p_sclk3) begin
                if (edges3 > 0) begin
                    if (lo_run3 < lo_min3) lo_min3 = lo_run3;
                    if (lo_run3 > lo_max3) lo_max3 = lo_run3;
                end
                edges3++;
                bits3 = {bits3[14:0], copi3};
                lo_run3 = 0;
            end else if (!sclk3 && edges3 > 0) begin
                lo_run3++;
            end
        end else if (!p_ncs3) begin
            frames3.push_back('{bits3, edges3, low3, 0, done3});
        end
        p_ncs3 = ncs3; p_sclk3 = sclk3; p_copi3 = copi3;
    end

    task automatic do_req(input logic rw, input logic [6:0] a, input logic [7:0] d, output bit ok);
        int t = 0;
        req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
        while (!req_ready && t < 3 * PERIOD) begin
            @(negedge clk);
            t++;
        end
        ok = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_frame(output frame_t f, output bit ok);
        int t = 0;
        while (frames.size() == 0 && t < 2 * PERIOD) begin
            @(negedge clk);
            t++;
        end
        ok = (frames.size() != 0);
        if (ok) f = frames.pop_front();
        else f = '{16'h0, 0, 0, 0, 1'b0};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({nCS, SCLK, COPI, busy, done, req_ready} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: {nCS,SCLK,COPI,busy,done,ready}=%b want 100000", i,
                         {nCS, SCLK, COPI, busy, done, req_ready});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({nCS, SCLK, COPI, busy, done, req_ready} !== 6'b100001) begin
                errors++;
                $display("FAIL reset_release cycle %0d: {nCS,SCLK,COPI,busy,done,ready}=%b want 100001", i,
                         {nCS, SCLK, COPI, busy, done, req_ready});
            end
        end
    endtask

    task automatic test_write_pwm();
        frame_t f;
        bit ok;
        int d0 = done_cnt;
        logic [15:0] exp_bits = {RW_WRITE, ADDR_PWM_DUTY, 8'hA5};
        do_req(RW_WRITE, ADDR_PWM_DUTY, 8'hA5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pwm_accept: req_ready never seen"); end
        checks++;
        if ({nCS, SCLK, COPI, busy} !== 4'b0011) begin
            errors++;
            $display("FAIL pwm_first_cycle: {nCS,SCLK,COPI,busy}=%b want 0011", {nCS, SCLK, COPI, busy});
        end
        get_frame(f, ok);
        ref_regs[ADDR_PWM_DUTY] = 8'hA5;
        checks++;
        if (!ok) begin errors++; $display("FAIL pwm_frame_timeout: no nCS rise seen"); end
        checks++;
        if (f.bits !== exp_bits || f.edges != 16) begin
            errors++;
            $display("FAIL pwm_bits: got %h/%0d edges want %h/16", f.bits, f.edges, exp_bits);
        end
        checks++;
        if (f.low_len != LOW_LEN) begin
            errors++; $display("FAIL pwm_ncs_low: got %0d want %0d", f.low_len, LOW_LEN);
        end
        checks++;
        if (f.done_at_rise !== 1'b1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL pwm_done: at_rise=%b pulses=%0d want 1/1", f.done_at_rise, done_cnt - d0);
        end
        checks++;
        if (bus_regs[ADDR_PWM_DUTY] !== ref_regs[ADDR_PWM_DUTY]) begin
            errors++;
            $display("FAIL pwm_duty_reg: got %h want %h", bus_regs[ADDR_PWM_DUTY], ref_regs[ADDR_PWM_DUTY]);
        end
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2;
        bit ok1, ok2;
        int n = captures.size();
        int t = 0;
        req_rw = RW_WRITE; req_addr = ADDR_EN_OUT_7_0; req_data = 8'hFF; req_valid = 1'b1;
        while (captures.size() <= n && t < 3 * PERIOD) begin @(negedge clk); t++; end
        req_addr = ADDR_EN_OUT_15_8; req_data = 8'h0F;
        t = 0;
        while (captures.size() <= n + 1 && t < 3 * PERIOD) begin @(negedge clk); t++; end
        req_valid = 1'b0;
        ref_regs[ADDR_EN_OUT_7_0]  = 8'hFF;
        ref_regs[ADDR_EN_OUT_15_8] = 8'h0F;
        get_frame(f1, ok1);
        get_frame(f2, ok2);
        checks++;
        if (captures.size() < n + 2) begin
            errors++; $display("FAIL b2b_captures: got %0d want %0d", captures.size() - n, 2);
        end else if (captures[n + 1] - captures[n] != PERIOD) begin
            errors++;
            $display("FAIL b2b_period: got %0d want %0d", captures[n + 1] - captures[n], PERIOD);
        end
        checks++;
        if (!ok1 || !ok2 || f1.bits !== {RW_WRITE, ADDR_EN_OUT_7_0, 8'hFF}
            || f2.bits !== {RW_WRITE, ADDR_EN_OUT_15_8, 8'h0F}) begin
            errors++;
            $display("FAIL b2b_bits: got %h %h want %h %h", f1.bits, f2.bits,
                     {RW_WRITE, ADDR_EN_OUT_7_0, 8'hFF}, {RW_WRITE, ADDR_EN_OUT_15_8, 8'h0F});
        end
        checks++;
        if (f2.gap_before < CS_GAP || f2.gap_before != PERIOD - LOW_LEN) begin
            errors++;
            $display("FAIL b2b_gap: got %0d want %0d (min %0d)", f2.gap_before, PERIOD - LOW_LEN, CS_GAP);
        end
        checks++;
        if (bus_regs[ADDR_EN_OUT_7_0] !== 8'hFF || bus_regs[ADDR_EN_OUT_15_8] !== 8'h0F) begin
            errors++;
            $display("FAIL b2b_regs: got %h %h want ff 0f", bus_regs[ADDR_EN_OUT_7_0], bus_regs[ADDR_EN_OUT_15_8]);
        end
    endtask

    task automatic test_data_hold();
        frame_t f;
        bit ok;
        do_req(RW_WRITE, 7'h10, 8'h3C, ok);
        req_data = 8'hC3; req_addr = 7'h7F; req_rw = 1'b0;
        repeat (40) @(negedge clk);
        req_data = 8'h81;
        ref_regs[7'h10] = 8'h3C;
        get_frame(f, ok);
        checks++;
        if (!ok || f.bits !== {RW_WRITE, 7'h10, 8'h3C}) begin
            errors++; $display("FAIL data_hold: got %h want %h", f.bits, {RW_WRITE, 7'h10, 8'h3C});
        end
    endtask

    task automatic test_random();
        frame_t f;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            logic       rw = 1'($urandom_range(0, 1));
            logic [6:0] a  = 7'($urandom_range(0, 7));
            logic [7:0] d  = 8'($urandom);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            do_req(rw, a, d, ok);
            if (rw == RW_WRITE) ref_regs[a] = d;
            get_frame(f, ok);
            checks++;
            if (!ok || f.bits !== {rw, a, d} || f.edges != 16 || f.low_len != LOW_LEN) begin
                errors++;
                $display("FAIL random_%0d: got %h/%0d/%0d want %h/16/%0d", k, f.bits, f.edges, f.low_len,
                         {rw, a, d}, LOW_LEN);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus_regs[i] !== ref_regs[i]) begin
                errors++; $display("FAIL random_reg_%0d: got %h want %h", i, bus_regs[i], ref_regs[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        frame_t f;
        bit ok;
        int d0 = done_cnt;
        do_req(RW_WRITE, ADDR_EN_PWM_7_0, 8'h77, ok);
        repeat (49) @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h05; req_data = 8'hEE;
        @(negedge clk);
        checks++;
        if ({nCS, SCLK, COPI, busy, done, req_ready} !== 6'b100000) begin
            errors++;
            $display("FAIL abort_outputs: {nCS,SCLK,COPI,busy,done,ready}=%b want 100000",
                     {nCS, SCLK, COPI, busy, done, req_ready});
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (nCS !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_rst_wins: nCS=%b busy=%b want 1/0", nCS, busy);
        end
        get_frame(f, ok);
        checks++;
        if (!ok || f.edges != 5 || f.low_len != 50 || f.done_at_rise !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_partial: edges=%0d low=%0d done=%b pulses=%0d want 5/50/0/0",
                     f.edges, f.low_len, f.done_at_rise, done_cnt - d0);
        end
        do_req(RW_WRITE, ADDR_EN_PWM_7_0, 8'h55, ok);
        ref_regs[ADDR_EN_PWM_7_0] = 8'h55;
        get_frame(f, ok);
        checks++;
        if (!ok || f.bits !== {RW_WRITE, ADDR_EN_PWM_7_0, 8'h55} || f.done_at_rise !== 1'b1
            || bus_regs[ADDR_EN_PWM_7_0] !== ref_regs[ADDR_EN_PWM_7_0]) begin
            errors++;
            $display("FAIL abort_recover: got %h reg=%h want %h reg=55", f.bits, bus_regs[ADDR_EN_PWM_7_0],
                     {RW_WRITE, ADDR_EN_PWM_7_0, 8'h55});
        end
    endtask

    task automatic test_clkdiv3();
        frame_t f;
        int t = 0;
        r3_rw = RW_WRITE; r3_addr = ADDR_EN_PWM_15_8; r3_data = 8'h5A; r3_valid = 1'b1;
        while (!r3_ready && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        r3_valid = 1'b0;
        t = 0;
        while (frames3.size() == 0 && t < 400) begin @(negedge clk); t++; end
        if (frames3.size() != 0) f = frames3.pop_front();
        else f = '{16'h0, 0, 0, 0, 1'b0};
        checks++;
        if (f.bits !== {RW_WRITE, ADDR_EN_PWM_15_8, 8'h5A} || f.edges != 16 || f.low_len != LOW_LEN3) begin
            errors++;
            $display("FAIL div3_frame: got %h/%0d/%0d want %h/16/%0d", f.bits, f.edges, f.low_len,
                     {RW_WRITE, ADDR_EN_PWM_15_8, 8'h5A}, LOW_LEN3);
        end
        checks++;
        if (hi_min3 != 3 || hi_max3 != 3 || lo_min3 != 3 || lo_max3 != 3) begin
            errors++;
            $display("FAIL div3_half_period: high %0d..%0d low %0d..%0d want 3", hi_min3, hi_max3, lo_min3, lo_max3);
        end
        checks++;
        if (viol3 != 0 || f.done_at_rise !== 1'b1) begin
            errors++; $display("FAIL div3_copi_done: violations=%0d done=%b want 0/1", viol3, f.done_at_rise);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL copi_while_sclk_high: got %0d want 0", viol); end
        checks++;
        if (inv_bad != 0) begin errors++; $display("FAIL ready_vs_busy: got %0d bad cycles want 0", inv_bad); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            bus_regs[i] = 8'h00;
            ref_regs[i] = 8'h00;
        end
        test_reset();
        test_write_pwm();
        test_back_to_back();
        test_data_hold();
        test_random();
        test_reset_abort();
        test_clkdiv3();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #6000000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

endmodule
